// File: rtl/frame_delay_bank_pkg.sv
// Shared definitions for the frame-counting delay timer bank.
// Holds the mode encodings, channel state enum and default counter width.
package frame_delay_bank_pkg;

  localparam int unsigned DELAY_SIGNAL_FRAMES_DELAY_WIDTH = 8;

  localparam logic FDB_MODE_ONESHOT  = 1'b0;
  localparam logic FDB_MODE_PERIODIC = 1'b1;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_COUNT = 2'd1,
    CH_DONE  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/frame_delay_channel.sv
// One timer channel: arms from IDLE, counts frame strobes, signals expiry.
// ONESHOT parks in DONE with a sticky flag; PERIODIC reloads and keeps counting.
module frame_delay_channel
  import frame_delay_bank_pkg::*;
#(
  parameter int unsigned DELAY_WIDTH     = DELAY_SIGNAL_FRAMES_DELAY_WIDTH,
  parameter int unsigned RESTART_ON_DROP = 0
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   start_of_frame,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   mode,
  input  logic [DELAY_WIDTH-1:0] delay_frames,
  output logic                   expired,
  output logic                   expire_pulse,
  output logic [DELAY_WIDTH-1:0] remaining
);

  ch_state_e              state_q, state_d;
  logic [DELAY_WIDTH-1:0] count_q, count_d;
  logic                   mode_q, mode_d;
  logic                   expired_q, expired_d;
  logic                   pulse_q, pulse_d;

  // State and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= CH_IDLE;
      count_q   <= '0;
      mode_q    <= FDB_MODE_ONESHOT;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
    end
  end

  // Next-state and next-output logic; clear overrides every other event
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mode_d    = mode_q;
    expired_d = expired_q;
    pulse_d   = 1'b0;

    if (clear) begin
      state_d   = CH_IDLE;
      count_d   = '0;
      expired_d = 1'b0;
    end else begin
      unique case (state_q)
        CH_IDLE: begin
          if (enable) begin
            count_d = delay_frames;
            mode_d  = mode;
            state_d = CH_COUNT;
          end
        end

        CH_COUNT: begin
          if (!enable) begin
            if (RESTART_ON_DROP != 0) begin
              state_d = CH_IDLE;
              count_d = '0;
            end
          end else if (start_of_frame) begin
            if (count_q != '0) begin
              count_d = count_q - DELAY_WIDTH'(1);
            end else begin
              pulse_d = 1'b1;
              if (mode_q == FDB_MODE_PERIODIC) begin
                count_d = delay_frames;
              end else begin
                state_d   = CH_DONE;
                expired_d = 1'b1;
              end
            end
          end
        end

        CH_DONE: begin
          expired_d = 1'b1;
        end

        default: begin
          state_d   = CH_IDLE;
          count_d   = '0;
          expired_d = 1'b0;
        end
      endcase
    end
  end

  assign expired      = expired_q;
  assign expire_pulse = pulse_q;
  assign remaining    = count_q;

endmodule

// File: rtl/frame_delay_bank.sv
// Bank of independent frame-counting delay timers sharing one frame strobe.
// The top only slices the packed per-channel buses onto channel instances.
module frame_delay_bank
  import frame_delay_bank_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned DELAY_WIDTH     = DELAY_SIGNAL_FRAMES_DELAY_WIDTH,
  parameter int unsigned RESTART_ON_DROP = 0
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                startOfFrame,
  input  logic [NUM_CHANNELS-1:0]             enable,
  input  logic [NUM_CHANNELS-1:0]             clear,
  input  logic [NUM_CHANNELS-1:0]             mode,
  input  logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delay_frames,
  output logic [NUM_CHANNELS-1:0]             expired,
  output logic [NUM_CHANNELS-1:0]             expire_pulse,
  output logic [NUM_CHANNELS*DELAY_WIDTH-1:0] remaining
);

  for (genvar i = 0; i < int'(NUM_CHANNELS); i++) begin : g_ch
    frame_delay_channel #(
      .DELAY_WIDTH    (DELAY_WIDTH),
      .RESTART_ON_DROP(RESTART_ON_DROP)
    ) u_ch (
      .clk           (clk),
      .resetN        (resetN),
      .start_of_frame(startOfFrame),
      .enable        (enable[i]),
      .clear         (clear[i]),
      .mode          (mode[i]),
      .delay_frames  (delay_frames[i*DELAY_WIDTH +: DELAY_WIDTH]),
      .expired       (expired[i]),
      .expire_pulse  (expire_pulse[i]),
      .remaining     (remaining[i*DELAY_WIDTH +: DELAY_WIDTH])
    );
  end

endmodule

// File: tb/tb_frame_delay_bank.sv
// Self-checking bench: two banks (hold-on-drop and restart-on-drop) on shared stimulus,
// compared every cycle against a frame-level behavioural model plus directed constants.
module tb_frame_delay_bank;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic clk = 1'b0;
  logic resetN;
  logic sof;
  logic [NCH-1:0]   en, clr, md;
  logic [NCH*W-1:0] dly;
  logic [NCH-1:0]   exp0, pls0, exp1, pls1;
  logic [NCH*W-1:0] rem0, rem1;

  always #5 clk = ~clk;

  frame_delay_bank #(.NUM_CHANNELS(NCH), .DELAY_WIDTH(W), .RESTART_ON_DROP(0)) dut0 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en), .clear(clr),
    .mode(md), .delay_frames(dly), .expired(exp0), .expire_pulse(pls0), .remaining(rem0));

  frame_delay_bank #(.NUM_CHANNELS(NCH), .DELAY_WIDTH(W), .RESTART_ON_DROP(1)) dut1 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en), .clear(clr),
    .mode(md), .delay_frames(dly), .expired(exp1), .expire_pulse(pls1), .remaining(rem1));

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Model per bank/channel: armed, finished (oneshot expired), frames left, latched mode
  bit m_act[2][NCH];
  bit m_fin[2][NCH];
  bit m_per[2][NCH];
  bit m_pls[2][NCH];
  int m_cnt[2][NCH];

  function automatic int dsel(int ch);
    return int'(dly[ch*W +: W]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < NCH; ch++) begin
        m_act[d][ch] = 0; m_fin[d][ch] = 0; m_per[d][ch] = 0;
        m_pls[d][ch] = 0; m_cnt[d][ch] = 0;
      end
  endtask

  task automatic model_tick();
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < NCH; ch++) begin
        m_pls[d][ch] = 0;
        if (clr[ch]) begin
          m_act[d][ch] = 0; m_fin[d][ch] = 0; m_cnt[d][ch] = 0;
        end else if (m_fin[d][ch]) begin
          m_fin[d][ch] = 1;
        end else if (!m_act[d][ch]) begin
          if (en[ch]) begin
            m_act[d][ch] = 1; m_cnt[d][ch] = dsel(ch); m_per[d][ch] = md[ch];
          end
        end else if (!en[ch]) begin
          if (d == 1) begin
            m_act[d][ch] = 0; m_cnt[d][ch] = 0;
          end
        end else if (sof) begin
          if (m_cnt[d][ch] > 0) m_cnt[d][ch] = m_cnt[d][ch] - 1;
          else begin
            m_pls[d][ch] = 1;
            if (m_per[d][ch]) m_cnt[d][ch] = dsel(ch);
            else begin
              m_fin[d][ch] = 1; m_act[d][ch] = 0;
            end
          end
        end
      end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0]   e_exp, e_pls;
    logic [NCH*W-1:0] e_rem;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        e_exp[ch] = m_fin[d][ch];
        e_pls[ch] = m_pls[d][ch];
        e_rem[ch*W +: W] = W'(m_cnt[d][ch]);
      end
      chk($sformatf("dut%0d_expired", d),   64'(d == 0 ? exp0 : exp1), 64'(e_exp));
      chk($sformatf("dut%0d_pulse", d),     64'(d == 0 ? pls0 : pls1), 64'(e_pls));
      chk($sformatf("dut%0d_remaining", d), 64'(d == 0 ? rem0 : rem1), 64'(e_rem));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask

  task automatic frame();
    sof = 1'b1; cyc();
    sof = 1'b0; cyc();
  endtask

  task automatic set_delay(input int ch, input int v);
    dly[ch*W +: W] = W'(v);
  endtask

  task automatic clear_all();
    en = '0; clr = '1; cyc(); clr = '0;
  endtask

  initial begin
    resetN = 1'b0; sof = 1'b0; en = '0; clr = '0; md = '0; dly = '0;
    model_reset();
    #12;
    check_all();
    chk("reset_remaining", 64'(rem0), 64'(0));
    @(negedge clk) resetN = 1'b1;

    // 1: oneshot D=3, expiry on 4th strobe, sticky for 10 more frames
    clear_all();
    set_delay(0, 3); md[0] = 1'b0; en[0] = 1'b1; cyc();
    chk("t1_armed_remaining", 64'(rem0[7:0]), 64'(3));
    for (int s = 1; s <= 3; s++) frame();
    sof = 1'b1; cyc();
    chk("t1_pulse", 64'(pls0[0]), 64'(1));
    chk("t1_expired", 64'(exp0[0]), 64'(1));
    sof = 1'b0; cyc();
    chk("t1_pulse_one_clk", 64'(pls0[0]), 64'(0));
    for (int s = 0; s < 10; s++) frame();
    chk("t1_expired_held", 64'(exp0[0]), 64'(1));

    // 2: periodic D=2, pulses on strobes 3, 6, 9
    clear_all();
    set_delay(1, 2); md[1] = 1'b1; en[1] = 1'b1; cyc();
    for (int s = 1; s <= 10; s++) begin
      sof = 1'b1; cyc();
      chk($sformatf("t2_pulse_s%0d", s), 64'(pls0[1]), 64'((s % 3) == 0));
      chk("t2_expired_low", 64'(exp0[1]), 64'(0));
      sof = 1'b0; cyc();
    end

    // 3/4: D=5, drop after 2 strobes; dut0 holds, dut1 restarts
    clear_all();
    set_delay(2, 5); md[2] = 1'b0; en[2] = 1'b1; cyc();
    frame(); frame();
    en[2] = 1'b0;
    for (int s = 0; s < 4; s++) frame();
    chk("t3_held_remaining", 64'(rem0[23:16]), 64'(3));
    chk("t4_dropped_remaining", 64'(rem1[23:16]), 64'(0));
    en[2] = 1'b1; cyc();
    chk("t4_rearm_remaining", 64'(rem1[23:16]), 64'(5));
    for (int s = 1; s <= 6; s++) begin
      sof = 1'b1; cyc();
      chk($sformatf("t3_pulse_s%0d", s), 64'(pls0[2]), 64'(s == 4));
      chk($sformatf("t4_pulse_s%0d", s), 64'(pls1[2]), 64'(s == 6));
      sof = 1'b0; cyc();
    end

    // 5: clear coincides with the expiring strobe
    clear_all();
    set_delay(3, 0); md[3] = 1'b0; en[3] = 1'b1; cyc();
    sof = 1'b1; clr[3] = 1'b1; cyc();
    chk("t5_no_pulse", 64'(pls0[3]), 64'(0));
    chk("t5_no_expired", 64'(exp0[3]), 64'(0));
    sof = 1'b0; clr[3] = 1'b0; en[3] = 1'b0; cyc();

    // 6: four channels, mixed modes, then async reset mid-count
    clear_all();
    set_delay(0, 0); set_delay(1, 1); set_delay(2, 2); set_delay(3, 255);
    md = 4'b1010; en = '1; cyc();
    for (int s = 0; s < 8; s++) frame();
    chk("t6_expired", 64'(exp0), 64'(4'b0101));
    chk("t6_ch3_remaining", 64'(rem0[31:24]), 64'(247));
    #2 resetN = 1'b0;
    #1 model_reset();
    check_all();
    chk("t6_reset_all", 64'({exp0, pls0, rem0}), 64'(0));
    en = '0;
    @(negedge clk) resetN = 1'b1;

    // Randomised traffic against the model
    for (int n = 0; n < 500; n++) begin
      sof = ($urandom_range(2) == 0);
      for (int ch = 0; ch < NCH; ch++) begin
        en[ch]  = ($urandom_range(7) != 0);
        clr[ch] = ($urandom_range(39) == 0);
        md[ch]  = 1'($urandom_range(1));
        if ($urandom_range(3) == 0)
          set_delay(ch, ($urandom_range(15) == 0) ? 255 : int'($urandom_range(5)));
      end
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
